// File: rtl/storage_req_bridge.sv
// Bridges the vector core req/gnt/rvalid memory port onto storage_controller's level-held
// memory_access/out_valid handshake, with an in-order request FIFO, timeout and programming-mode blocking.
module storage_req_bridge #(
  parameter int MEM_W          = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_i,
  output logic               mem_gnt_o,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic               mem_err_o,
  output logic [MEM_W-1:0]   mem_rdata_o,
  input  logic               programming_mode_i,
  output logic               memory_access_o,
  output logic               memory_is_writing_o,
  output logic [31:0]        addr_o,
  output logic [MEM_W-1:0]   d_in_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  input  logic [MEM_W-1:0]   d_out_i,
  input  logic               out_valid_i,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int BE_W = MEM_W / 8;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, PROG} state_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [MEM_W-1:0] wdata;
    logic [BE_W-1:0]  be;
    logic             we;
  } req_t;

  state_t          state_q, state_d;
  req_t            fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt_q;
  req_t            incoming, head, load_src;
  logic            fifo_empty, fifo_full, push, bypass, fifo_wr;
  logic            pop, load, resp_v, resp_err, set_timeout;
  logic [MEM_W-1:0] resp_data;

  assign incoming   = '{addr: mem_addr_i, wdata: mem_wdata_i, be: mem_be_i, we: mem_we_i};
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign mem_gnt_o = mem_req_i & ~fifo_full & ~programming_mode_i;
  assign push      = mem_req_i & mem_gnt_o;
  // A request arriving into an empty FIFO while idle skips the FIFO to meet one-cycle issue latency.
  assign bypass    = push & fifo_empty & (state_q == IDLE);
  assign fifo_wr   = push & ~bypass;
  assign load_src  = fifo_empty ? incoming : head;

  assign memory_access_o = (state_q == ISSUE);
  assign busy_o          = ~fifo_empty | (state_q == ISSUE) | (state_q == GAP);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load        = 1'b0;
    resp_v      = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;
    set_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (programming_mode_i) begin
          state_d = PROG;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = ISSUE;
        end else if (bypass) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (out_valid_i) begin
          resp_v    = 1'b1;
          resp_data = memory_is_writing_o ? '0 : d_out_i;
          state_d   = GAP;
        end else if (programming_mode_i) begin
          resp_v   = 1'b1;
          resp_err = 1'b1;
          state_d  = PROG;
        end else if (cnt_q == CNT_LAST) begin
          resp_v      = 1'b1;
          resp_err    = 1'b1;
          set_timeout = 1'b1;
          state_d     = GAP;
        end
      end
      GAP: state_d = IDLE;
      PROG: begin
        // Drain queued requests with error responses while the controller is being programmed.
        if (!programming_mode_i) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          resp_v   = 1'b1;
          resp_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= incoming;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= IDLE;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      cnt_q               <= '0;
      addr_o              <= '0;
      d_in_o              <= '0;
      mem_be_o            <= '0;
      memory_is_writing_o <= 1'b0;
      mem_rvalid_o        <= 1'b0;
      mem_err_o           <= 1'b0;
      mem_rdata_o         <= '0;
      timeout_o           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      cnt_q <= (state_q == ISSUE && state_d == ISSUE) ? cnt_q + CW'(1) : '0;
      if (load) begin
        addr_o              <= load_src.addr;
        d_in_o              <= load_src.wdata;
        mem_be_o            <= load_src.be;
        memory_is_writing_o <= load_src.we;
      end
      mem_rvalid_o <= resp_v;
      mem_err_o    <= resp_err;
      mem_rdata_o  <= resp_data;
      if (set_timeout) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_storage_req_bridge.sv
// Scoreboard bench for storage_req_bridge: directed requests push expected responses,
// a negedge monitor pops/compares rvalids and checks controller-side handshake rules.
module tb_storage_req_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_i = 1'b0;
  logic        mem_gnt_o;
  logic [31:0] mem_addr_i = '0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_be_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_rvalid_o, mem_err_o;
  logic [31:0] mem_rdata_o;
  logic        programming_mode_i = 1'b0;
  logic        memory_access_o, memory_is_writing_o;
  logic [31:0] addr_o, d_in_o;
  logic [3:0]  mem_be_o;
  logic [31:0] d_out_i = '0;
  logic        out_valid_i = 1'b0;
  logic        busy_o, timeout_o;

  storage_req_bridge #(.MEM_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
    .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_err_o(mem_err_o), .mem_rdata_o(mem_rdata_o),
    .programming_mode_i(programming_mode_i), .memory_access_o(memory_access_o),
    .memory_is_writing_o(memory_is_writing_o), .addr_o(addr_o), .d_in_o(d_in_o),
    .mem_be_o(mem_be_o), .d_out_i(d_out_i), .out_valid_i(out_valid_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   ctrl_delay = 0;
  int   acc_cnt = 0;
  int   acc_run = 0;
  int   low_run = 0;
  int   last_acc_len = 0;
  logic prev_acc = 1'b0;
  logic seen_acc = 1'b0;
  logic gnt_dropped = 1'b0;
  logic [31:0] held_addr, held_din;
  logic [3:0]  held_be;
  logic        held_we;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_dout(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'hDEADBEEF : ~a;
  endfunction

  // Controller model: answers after ctrl_delay cycles of access high (0 = never answers).
  always @(negedge clk) begin
    if (rst || !memory_access_o) begin
      acc_cnt     = 0;
      out_valid_i = 1'b0;
    end else begin
      acc_cnt++;
      if (ctrl_delay != 0 && acc_cnt == ctrl_delay) begin
        out_valid_i = 1'b1;
        d_out_i     = model_dout(addr_o);
      end else begin
        out_valid_i = 1'b0;
        d_out_i     = 32'h55AA_55AA;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 1'b0;
      seen_acc = 1'b0;
      acc_run  = 0;
      low_run  = 0;
    end else begin
      if (mem_rvalid_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rvalid", {31'd0, mem_rvalid_o}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("rsp_err", {31'd0, mem_err_o}, {31'd0, e.err});
          checkOutput("rsp_rdata", mem_rdata_o, e.rdata);
        end
      end
      if (memory_access_o) begin
        if (!prev_acc) begin
          if (seen_acc) checkOutput("issue_gap_ge2", {31'd0, low_run >= 2}, 32'd1);
          seen_acc = 1'b1;
          acc_run  = 1;
        end else begin
          acc_run++;
          checkOutput("addr_stable", addr_o, held_addr);
          checkOutput("din_stable", d_in_o, held_din);
          checkOutput("be_stable", {28'd0, mem_be_o}, {28'd0, held_be});
          checkOutput("we_stable", {31'd0, memory_is_writing_o}, {31'd0, held_we});
        end
        held_addr = addr_o;
        held_din  = d_in_o;
        held_be   = mem_be_o;
        held_we   = memory_is_writing_o;
      end else begin
        if (prev_acc) begin
          last_acc_len = acc_run;
          low_run      = 1;
        end else begin
          low_run++;
        end
      end
      prev_acc = memory_access_o;
    end
  end

  // Called at a negedge; holds the request until granted and records the expected response.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rdata);
    int n = 0;
    mem_req_i   = 1'b1;
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    mem_be_i    = be;
    #1;
    while (!mem_gnt_o && n < 200) begin
      gnt_dropped = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    if (!mem_gnt_o) begin
      checkOutput("gnt_wait", {31'd0, mem_gnt_o}, 32'd1);
    end else begin
      sb.push_back('{err: exp_err, rdata: exp_rdata});
    end
    @(negedge clk);
    mem_req_i = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy_o)
      checkOutput("wait_idle", {31'd0, busy_o | (sb.size() != 0)}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitAccess(input int budget);
    int n = 0;
    while (!memory_access_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!memory_access_o) checkOutput("wait_access", {31'd0, memory_access_o}, 32'd1);
  endtask

  logic [31:0] t3_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
  logic [31:0] t3_exp  [6] = '{32'hFFFF_FEFF, 32'hFFFF_FEFB, 32'hFFFF_FEF7,
                               32'hFFFF_FEF3, 32'hFFFF_FEEF, 32'hFFFF_FEEB};

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_access", {31'd0, memory_access_o}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, mem_rvalid_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout_o}, 32'd0);
    checkOutput("rst_addr", addr_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: single read");
    ctrl_delay = 2;
    applyStimulus(1'b0, 32'h0000_0040, 32'd0, 4'hF, 1'b0, 32'hDEADBEEF);
    waitIdle(100);
    checkOutput("t1_access_len", last_acc_len, 32'd2);

    $display("[TB] test 2: single write");
    ctrl_delay = 3;
    applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 32'd0);
    waitAccess(20);
    checkOutput("t2_addr", addr_o, 32'h0000_0010);
    checkOutput("t2_din", d_in_o, 32'h1234_5678);
    checkOutput("t2_be", {28'd0, mem_be_o}, 32'hF);
    checkOutput("t2_we", {31'd0, memory_is_writing_o}, 32'd1);
    waitIdle(100);
    checkOutput("t2_access_len", last_acc_len, 32'd3);

    $display("[TB] test 3: six back-to-back reads");
    ctrl_delay  = 10;
    gnt_dropped = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, t3_addr[i], 32'd0, 4'hF, 1'b0, t3_exp[i]);
    checkOutput("t3_gnt_dropped", {31'd0, gnt_dropped}, 32'd1);
    waitIdle(400);

    $display("[TB] test 4: timeout");
    ctrl_delay = 0;
    applyStimulus(1'b0, 32'h0000_4000, 32'd0, 4'hF, 1'b1, 32'd0);
    waitIdle(100);
    checkOutput("t4_access_len", last_acc_len, 32'd16);
    checkOutput("t4_timeout", {31'd0, timeout_o}, 32'd1);
    ctrl_delay = 1;
    applyStimulus(1'b0, 32'h0000_0080, 32'd0, 4'hF, 1'b0, 32'hFFFF_FF7F);
    waitIdle(100);
    checkOutput("t4_timeout_sticky", {31'd0, timeout_o}, 32'd1);

    $display("[TB] test 5: programming mode during issue");
    ctrl_delay = 10;
    applyStimulus(1'b0, 32'h0000_0200, 32'd0, 4'hF, 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h0000_0204, 32'd0, 4'hF, 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h0000_0208, 32'd0, 4'hF, 1'b1, 32'd0);
    checkOutput("t5_access_before", {31'd0, memory_access_o}, 32'd1);
    programming_mode_i = 1'b1;
    @(negedge clk);
    checkOutput("t5_access_dropped", {31'd0, memory_access_o}, 32'd0);
    mem_req_i  = 1'b1;
    mem_addr_i = 32'h0000_0300;
    mem_we_i   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("t5_gnt_blocked", {31'd0, mem_gnt_o}, 32'd0);
      @(negedge clk);
    end
    mem_req_i = 1'b0;
    checkOutput("t5_all_answered", sb.size(), 32'd0);
    programming_mode_i = 1'b0;
    @(negedge clk);
    ctrl_delay = 2;
    applyStimulus(1'b0, 32'h0000_0300, 32'd0, 4'hF, 1'b0, 32'hFFFF_FCFF);
    waitIdle(100);

    $display("[TB] test 6: reset mid-transaction");
    ctrl_delay = 10;
    applyStimulus(1'b0, 32'h0000_0400, 32'd0, 4'hF, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h0000_0404, 32'd0, 4'hF, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h0000_0408, 32'd0, 4'hF, 1'b0, 32'd0);
    checkOutput("t6_access_before", {31'd0, memory_access_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_access", {31'd0, memory_access_o}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("t6_timeout", {31'd0, timeout_o}, 32'd0);
    checkOutput("t6_addr", addr_o, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("t6_busy_after", {31'd0, busy_o}, 32'd0);
    checkOutput("t6_access_after", {31'd0, memory_access_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
